// File: rtl/axi_rd_arbiter.sv
// Round-robin arbiter sharing one AXI read channel (AR + R) among N cache-side requesters.
// Optional macro RD_ARB_PRIO_EN: PRIO_PORT wins any IDLE grant it is eligible for.
module axi_rd_arbiter #(
  parameter int N         = 3,
  parameter int PRIO_PORT = 1
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [N-1:0]    req_valid_i,
  input  logic [N*32-1:0] req_addr_i,
  input  logic [N*8-1:0]  req_len_i,
  input  logic [N*3-1:0]  req_size_i,
  output logic [N-1:0]    req_ready_o,
  output logic [N-1:0]    rsp_valid_o,
  output logic [31:0]     rsp_data_o,
  output logic            rsp_last_o,
  output logic [N-1:0]    busy_o,
  output logic            bad_rid_o,
  output logic [3:0]      axi_arid_o,
  output logic [31:0]     axi_araddr_o,
  output logic [7:0]      axi_arlen_o,
  output logic [2:0]      axi_arsize_o,
  output logic [1:0]      axi_arburst_o,
  output logic            axi_arvalid_o,
  input  logic            axi_arready_i,
  input  logic [3:0]      axi_rid_i,
  input  logic [31:0]     axi_rdata_i,
  input  logic [1:0]      axi_rresp_i,
  input  logic            axi_rlast_i,
  input  logic            axi_rvalid_i,
  output logic            axi_rready_o
);

  localparam int PW = $clog2(N);

  typedef enum logic {IDLE, SEND} state_e;

  if (N < 2 || N > 4) begin : g_bad_n
    $error("axi_rd_arbiter: N must be in 2..4");
  end
  if (PRIO_PORT < 0 || PRIO_PORT >= N) begin : g_bad_prio
    $error("axi_rd_arbiter: PRIO_PORT must be below N");
  end

  state_e        state_q, state_d;
  logic [N-1:0]  busy_q, busy_d;
  logic [PW-1:0] rr_ptr_q, rr_ptr_d;
  logic          bad_rid_q, bad_rid_d;
  logic          prio_q, prio_d;
  logic [3:0]    arid_q, arid_d;
  logic [31:0]   araddr_q, araddr_d;
  logic [7:0]    arlen_q, arlen_d;
  logic [2:0]    arsize_q, arsize_d;

  logic [N-1:0]  elig;
  logic          found;
  logic          prio_grant;
  logic [PW-1:0] win;
  logic          rid_hit;

  // The response code is deliberately ignored; beats are forwarded regardless.
  logic unused_rresp;
  assign unused_rresp = ^axi_rresp_i;

  // Winner search: first eligible requester at or after rr_ptr, wrapping mod N.
  always_comb begin
    elig       = req_valid_i & ~busy_q;
    found      = 1'b0;
    prio_grant = 1'b0;
    win        = '0;
    for (int k = 0; k < N; k++) begin
      for (int j = 0; j < N; j++) begin
        if (!found && elig[j] &&
            ((int'(rr_ptr_q) + k == j) || (int'(rr_ptr_q) + k == j + N))) begin
          found = 1'b1;
          win   = PW'(j);
        end
      end
    end
`ifdef RD_ARB_PRIO_EN
    if (elig[PRIO_PORT]) begin
      found      = 1'b1;
      prio_grant = 1'b1;
      win        = PW'(PRIO_PORT);
    end
`else
    prio_grant = 1'b0;
`endif
  end

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    rr_ptr_d    = rr_ptr_q;
    bad_rid_d   = bad_rid_q;
    prio_d      = prio_q;
    arid_d      = arid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    arsize_d    = arsize_q;
    req_ready_o = '0;
    rid_hit     = 1'b0;

    case (state_q)
      IDLE: begin
        if (found) begin
          req_ready_o[win] = 1'b1;
          arid_d           = 4'(win);
          prio_d           = prio_grant;
          state_d          = SEND;
          for (int j = 0; j < N; j++) begin
            if (win == PW'(j)) begin
              araddr_d = req_addr_i[j*32 +: 32];
              arlen_d  = req_len_i[j*8 +: 8];
              arsize_d = req_size_i[j*3 +: 3];
            end
          end
        end
      end
      SEND: begin
        if (axi_arready_i) begin
          for (int j = 0; j < N; j++) begin
            if (arid_q == 4'(j)) begin
              busy_d[j] = 1'b1;
              if (!prio_q) rr_ptr_d = (j == N - 1) ? '0 : PW'(j + 1);
            end
          end
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // A last beat never targets the index just handshaken, since a busy requester cannot win.
    if (axi_rvalid_i) begin
      for (int j = 0; j < N; j++) begin
        if (axi_rid_i == 4'(j) && busy_q[j]) begin
          rid_hit = 1'b1;
          if (axi_rlast_i) busy_d[j] = 1'b0;
        end
      end
      if (!rid_hit) bad_rid_d = 1'b1;
    end
  end

  always_comb begin
    rsp_valid_o = '0;
    for (int j = 0; j < N; j++) begin
      rsp_valid_o[j] = axi_rvalid_i && (axi_rid_i == 4'(j)) && busy_q[j];
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      busy_q    <= '0;
      rr_ptr_q  <= '0;
      bad_rid_q <= 1'b0;
      prio_q    <= 1'b0;
      arid_q    <= '0;
      araddr_q  <= '0;
      arlen_q   <= '0;
      arsize_q  <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      rr_ptr_q  <= rr_ptr_d;
      bad_rid_q <= bad_rid_d;
      prio_q    <= prio_d;
      arid_q    <= arid_d;
      araddr_q  <= araddr_d;
      arlen_q   <= arlen_d;
      arsize_q  <= arsize_d;
    end
  end

  assign axi_arvalid_o = (state_q == SEND);
  assign axi_arid_o    = arid_q;
  assign axi_araddr_o  = araddr_q;
  assign axi_arlen_o   = arlen_q;
  assign axi_arsize_o  = arsize_q;
  assign axi_arburst_o = 2'b01;
  assign axi_rready_o  = 1'b1;
  assign rsp_data_o    = axi_rdata_i;
  assign rsp_last_o    = axi_rlast_i;
  assign busy_o        = busy_q;
  assign bad_rid_o     = bad_rid_q;

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Table-driven bench for axi_rd_arbiter (N=3): one vector per clock cycle, plus hand sequences
// for reset values and a bounded wait on the AR handshake.
module tb_axi_rd_arbiter;

  localparam int N = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  reqValid;
  logic [N*32-1:0] reqAddr;
  logic [N*8-1:0]  reqLen;
  logic [N*3-1:0]  reqSize;
  logic [N-1:0]  reqReady, rspValid, busy;
  logic [31:0]   rspData;
  logic          rspLast, badRid;
  logic [3:0]    arId;
  logic [31:0]   arAddr;
  logic [7:0]    arLen;
  logic [2:0]    arSize;
  logic [1:0]    arBurst;
  logic          arValid, arReady;
  logic [3:0]    rId;
  logic [31:0]   rData;
  logic [1:0]    rResp;
  logic          rLast, rValid, rReady;

  axi_rd_arbiter #(.N(N), .PRIO_PORT(1)) dut (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(reqValid), .req_addr_i(reqAddr), .req_len_i(reqLen), .req_size_i(reqSize),
    .req_ready_o(reqReady), .rsp_valid_o(rspValid), .rsp_data_o(rspData), .rsp_last_o(rspLast),
    .busy_o(busy), .bad_rid_o(badRid),
    .axi_arid_o(arId), .axi_araddr_o(arAddr), .axi_arlen_o(arLen), .axi_arsize_o(arSize),
    .axi_arburst_o(arBurst), .axi_arvalid_o(arValid), .axi_arready_i(arReady),
    .axi_rid_i(rId), .axi_rdata_i(rData), .axi_rresp_i(rResp), .axi_rlast_i(rLast),
    .axi_rvalid_i(rValid), .axi_rready_o(rReady)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         doRst;
    logic [2:0] reqV;
    logic       ardy;
    logic       rvld;
    logic [3:0] rid;
    logic       rlst;
    logic [2:0] expReady;
    logic       expArValid;
    logic       chkAr;
    logic [1:0] expArId;
    logic [2:0] expBusy;
    logic [2:0] expRsp;
    logic       expBad;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   failures = 0;
  int   curRow = -1;

  logic [31:0] addrTab [N] = '{32'h0000_1000, 32'h1fc0_0040, 32'h8000_0020};
  logic [7:0]  lenTab  [N] = '{8'd15, 8'd3, 8'd0};
  logic [2:0]  sizeTab [N] = '{3'd2, 3'd2, 3'd1};

  task automatic addVec(input bit rst, input logic [2:0] rv, input logic ar, input logic rvl,
                        input logic [3:0] rid, input logic rl, input logic [2:0] eRdy,
                        input logic eArv, input logic chk, input logic [1:0] eId,
                        input logic [2:0] eBusy, input logic [2:0] eRsp, input logic eBad);
    vec_t v;
    v.doRst = rst; v.reqV = rv; v.ardy = ar; v.rvld = rvl; v.rid = rid; v.rlst = rl;
    v.expReady = eRdy; v.expArValid = eArv; v.chkAr = chk; v.expArId = eId;
    v.expBusy = eBusy; v.expRsp = eRsp; v.expBad = eBad;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s row=%0d got=%h expected=%h", name, curRow, act, exp);
    end
  endtask

  task automatic idleInputs();
    reqValid = '0; arReady = 1'b0; rValid = 1'b0; rId = '0; rLast = 1'b0;
    rData = '0; rResp = '0;
  endtask

  // Called at posedge+1: holds reset across exactly one rising edge.
  task automatic doReset();
    reset = 1'b1;
    idleInputs();
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic applyStimulus(input vec_t v, input int idx);
    reqValid = v.reqV;
    arReady  = v.ardy;
    rValid   = v.rvld;
    rId      = v.rid;
    rLast    = v.rlst;
    rData    = 32'hD000_0000 | 32'(idx);
    rResp    = v.rvld ? 2'b10 : 2'b00;
  endtask

  task automatic checkVector(input vec_t v);
    checkOutput("reqReady", 32'(reqReady), 32'(v.expReady));
    checkOutput("arValid", 32'(arValid), 32'(v.expArValid));
    checkOutput("busy", 32'(busy), 32'(v.expBusy));
    checkOutput("rspValid", 32'(rspValid), 32'(v.expRsp));
    checkOutput("badRid", 32'(badRid), 32'(v.expBad));
    checkOutput("rspLast", 32'(rspLast), 32'(v.rlst));
    if (v.rvld) checkOutput("rspData", rspData, rData);
    if (v.chkAr) begin
      checkOutput("arId", 32'(arId), 32'(v.expArId));
      checkOutput("arAddr", arAddr, addrTab[v.expArId]);
      checkOutput("arLen", 32'(arLen), 32'(lenTab[v.expArId]));
      checkOutput("arSize", 32'(arSize), 32'(sizeTab[v.expArId]));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at %0t", $time);
    $fatal(1, "[TB] timeout");
  end

  initial begin
    int pulses;
    bit seen;
    for (int i = 0; i < N; i++) begin
      reqAddr[i*32 +: 32] = addrTab[i];
      reqLen[i*8 +: 8]    = lenTab[i];
      reqSize[i*3 +: 3]   = sizeTab[i];
    end

    //     rst rv    ar   rvl  rid rl  eRdy  eArv chk id eBusy  eRsp   eBad
    // Single request from requester 1, arready on the second SEND cycle, 4 beats.
    addVec(1, 3'b010, 0, 0, 0, 0, 3'b010, 0, 0, 0, 3'b000, 3'b000, 0);
    addVec(0, 3'b000, 0, 0, 0, 0, 3'b000, 1, 1, 1, 3'b000, 3'b000, 0);
    addVec(0, 3'b000, 1, 0, 0, 0, 3'b000, 1, 1, 1, 3'b000, 3'b000, 0);
    addVec(0, 3'b000, 0, 1, 1, 0, 3'b000, 0, 1, 1, 3'b010, 3'b010, 0);
    addVec(0, 3'b000, 0, 1, 1, 0, 3'b000, 0, 0, 0, 3'b010, 3'b010, 0);
    addVec(0, 3'b000, 0, 1, 1, 0, 3'b000, 0, 0, 0, 3'b010, 3'b010, 0);
    addVec(0, 3'b000, 0, 1, 1, 1, 3'b000, 0, 0, 0, 3'b010, 3'b010, 0);
    addVec(0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 1, 1, 3'b000, 3'b000, 0);
    // Round robin 0/2 with single-beat responses returned at once.
    addVec(1, 3'b101, 1, 0, 0, 0, 3'b001, 0, 0, 0, 3'b000, 3'b000, 0);
    addVec(0, 3'b101, 1, 0, 0, 0, 3'b000, 1, 1, 0, 3'b000, 3'b000, 0);
    addVec(0, 3'b101, 1, 1, 0, 1, 3'b100, 0, 0, 0, 3'b001, 3'b001, 0);
    addVec(0, 3'b101, 1, 0, 0, 0, 3'b000, 1, 1, 2, 3'b000, 3'b000, 0);
    addVec(0, 3'b101, 1, 1, 2, 1, 3'b001, 0, 0, 0, 3'b100, 3'b100, 0);
    addVec(0, 3'b101, 1, 0, 0, 0, 3'b000, 1, 1, 0, 3'b000, 3'b000, 0);
    addVec(0, 3'b101, 1, 1, 0, 1, 3'b100, 0, 0, 0, 3'b001, 3'b001, 0);
    addVec(0, 3'b101, 1, 0, 0, 0, 3'b000, 1, 1, 2, 3'b000, 3'b000, 0);
    // Stray rid 5, beat for an idle requester, then reset while in SEND.
    addVec(1, 3'b000, 0, 1, 5, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0);
    addVec(0, 3'b100, 0, 0, 0, 0, 3'b100, 0, 0, 0, 3'b000, 3'b000, 1);
    addVec(0, 3'b000, 1, 0, 0, 0, 3'b000, 1, 1, 2, 3'b000, 3'b000, 1);
    addVec(0, 3'b001, 0, 1, 0, 0, 3'b001, 0, 0, 0, 3'b100, 3'b000, 1);
    addVec(0, 3'b000, 0, 0, 0, 0, 3'b000, 1, 1, 0, 3'b100, 3'b000, 1);
    addVec(1, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0);
    addVec(0, 3'b000, 0, 1, 2, 1, 3'b000, 0, 0, 0, 3'b000, 3'b000, 0);
    addVec(0, 3'b000, 0, 0, 0, 0, 3'b000, 0, 0, 0, 3'b000, 3'b000, 1);
`ifdef RD_ARB_PRIO_EN
    // Priority port 1 wins first without moving rr_ptr, so 0 follows.
    addVec(1, 3'b011, 1, 0, 0, 0, 3'b010, 0, 0, 0, 3'b000, 3'b000, 0);
    addVec(0, 3'b011, 1, 0, 0, 0, 3'b000, 1, 1, 1, 3'b000, 3'b000, 0);
    addVec(0, 3'b011, 1, 0, 0, 0, 3'b001, 0, 0, 0, 3'b010, 3'b000, 0);
    addVec(0, 3'b011, 1, 0, 0, 0, 3'b000, 1, 1, 0, 3'b010, 3'b000, 0);
`else
    // Contention from reset: grants 0,1,2 two cycles apart, then nothing.
    addVec(1, 3'b111, 1, 0, 0, 0, 3'b001, 0, 0, 0, 3'b000, 3'b000, 0);
    addVec(0, 3'b111, 1, 0, 0, 0, 3'b000, 1, 1, 0, 3'b000, 3'b000, 0);
    addVec(0, 3'b111, 1, 0, 0, 0, 3'b010, 0, 0, 0, 3'b001, 3'b000, 0);
    addVec(0, 3'b111, 1, 0, 0, 0, 3'b000, 1, 1, 1, 3'b001, 3'b000, 0);
    addVec(0, 3'b111, 1, 0, 0, 0, 3'b100, 0, 0, 0, 3'b011, 3'b000, 0);
    addVec(0, 3'b111, 1, 0, 0, 0, 3'b000, 1, 1, 2, 3'b011, 3'b000, 0);
    addVec(0, 3'b111, 1, 0, 0, 0, 3'b000, 0, 1, 2, 3'b111, 3'b000, 0);
    addVec(0, 3'b111, 1, 0, 0, 0, 3'b000, 0, 0, 0, 3'b111, 3'b000, 0);
    // Interleaved R for ids 0 and 1; last beat of 1 lands with the AR handshake for 2.
    addVec(1, 3'b011, 1, 0, 0, 0, 3'b001, 0, 0, 0, 3'b000, 3'b000, 0);
    addVec(0, 3'b011, 1, 0, 0, 0, 3'b000, 1, 1, 0, 3'b000, 3'b000, 0);
    addVec(0, 3'b011, 1, 0, 0, 0, 3'b010, 0, 0, 0, 3'b001, 3'b000, 0);
    addVec(0, 3'b011, 1, 0, 0, 0, 3'b000, 1, 1, 1, 3'b001, 3'b000, 0);
    addVec(0, 3'b011, 1, 1, 1, 0, 3'b000, 0, 0, 0, 3'b011, 3'b010, 0);
    addVec(0, 3'b011, 1, 1, 0, 0, 3'b000, 0, 0, 0, 3'b011, 3'b001, 0);
    addVec(0, 3'b011, 1, 1, 1, 0, 3'b000, 0, 0, 0, 3'b011, 3'b010, 0);
    addVec(0, 3'b111, 1, 1, 1, 0, 3'b100, 0, 0, 0, 3'b011, 3'b010, 0);
    addVec(0, 3'b111, 1, 1, 1, 1, 3'b000, 1, 1, 2, 3'b011, 3'b010, 0);
    addVec(0, 3'b111, 0, 1, 0, 0, 3'b010, 0, 0, 0, 3'b101, 3'b001, 0);
    addVec(0, 3'b111, 0, 1, 0, 1, 3'b000, 1, 1, 1, 3'b101, 3'b001, 0);
    addVec(0, 3'b111, 0, 0, 0, 0, 3'b000, 1, 1, 1, 3'b100, 3'b000, 0);
`endif

    reset = 1'b1;
    idleInputs();
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset values.
    #4;
    checkOutput("rstArValid", 32'(arValid), 32'd0);
    checkOutput("rstArId", 32'(arId), 32'd0);
    checkOutput("rstArAddr", arAddr, 32'd0);
    checkOutput("rstArLen", 32'(arLen), 32'd0);
    checkOutput("rstArSize", 32'(arSize), 32'd0);
    checkOutput("rstBusy", 32'(busy), 32'd0);
    checkOutput("rstBadRid", 32'(badRid), 32'd0);
    checkOutput("rstReqReady", 32'(reqReady), 32'd0);
    checkOutput("arBurst", 32'(arBurst), 32'd1);
    checkOutput("rReady", 32'(rReady), 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      curRow = i;
      if (vecs[i].doRst) doReset();
      applyStimulus(vecs[i], i);
      #4;
      checkVector(vecs[i]);
      @(posedge clk); #1;
    end

    // Bounded wait for AR after a fresh request from requester 2.
    curRow = -2;
    doReset();
    reqValid = 3'b100;
    pulses = 0;
    seen = 1'b0;
    for (int c = 0; c < 8 && !seen; c++) begin
      #4;
      if (reqReady[2]) pulses++;
      if (arValid) seen = 1'b1;
      else begin
        @(posedge clk); #1;
      end
    end
    checkOutput("arWait", 32'(seen), 32'd1);
    checkOutput("arWaitId", 32'(arId), 32'd2);
    checkOutput("readyPulses", 32'(pulses), 32'd1);
    arReady = 1'b1;
    @(posedge clk); #1;
    arReady = 1'b0;
    reqValid = '0;
    #4;
    checkOutput("busyAfterAr", 32'(busy), 32'b100);
    checkOutput("arValidAfterAr", 32'(arValid), 32'd0);
    @(posedge clk); #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
